// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_HOLD   = 3'd1,
        PC_JUMP   = 3'd2,
        PC_RET    = 3'd3,
        PC_BRANCH = 3'd4
    } pc_sel_e;

    localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage : pc_pkg

// File: rtl/return_stack.sv
// Circular return-address LIFO: a push when full overwrites the oldest entry and the count saturates.
// A simultaneous push and pop replaces the top entry (or pushes onto an empty stack).
module return_stack #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, full_q;
    logic              wr_en_c;
    logic [PTR_W-1:0]  wr_idx_c;
    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];

    // ptr_q is the next free slot; the top lives one below it (modulo depth).
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wr_en_c  = 1'b0;
        wr_idx_c = ptr_q;
        if (push_i && pop_i) begin
            wr_en_c = 1'b1;
            if (cnt_q != CNT_W'(0)) begin
                wr_idx_c = ptr_q - PTR_W'(1);
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
                cnt_d = CNT_W'(1);
            end
        end else if (push_i) begin
            wr_en_c = 1'b1;
            ptr_d   = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && (cnt_q != CNT_W'(0))) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == CNT_W'(0));
            full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
        end
    end

    // Entries are only meaningful below the count, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_idx_c] <= data_i;
        end
    end

    assign top_o   = mem_q[ptr_q - PTR_W'(1)];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule : return_stack

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register and next-address selection (branch > ret > jump > stall > sequential).
// Define PC_SEQUENCER_RAS_EN to build in the return-address stack used to predict ret targets.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       INC       = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] link_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              redirect,
    output logic              ras_empty,
    output logic              ras_full
);

    pc_sel_e           sel_c;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_target_c;

    always_comb begin
        sel_c = PC_SEQ;
        if (branch_taken) begin
            sel_c = PC_BRANCH;
        end else if (ret) begin
            sel_c = PC_RET;
        end else if (jump) begin
            sel_c = PC_JUMP;
        end else if (stall) begin
            sel_c = PC_HOLD;
        end
    end

    always_comb begin
        pc_d     = pc_q + ADDR_W'(INC);
        redirect = 1'b0;
        case (sel_c)
            PC_BRANCH: begin
                pc_d     = branch_target;
                redirect = 1'b1;
            end
            PC_RET: begin
                pc_d     = ret_target_c;
                redirect = 1'b1;
            end
            PC_JUMP: begin
                pc_d     = jump_target;
                redirect = 1'b1;
            end
            PC_HOLD: pc_d = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

`ifdef PC_SEQUENCER_RAS_EN
    logic              push_c, pop_c;
    logic              stk_empty, stk_full;
    logic [ADDR_W-1:0] stk_top;

    // A branch squashes any concurrent stack traffic; call only counts alongside jump.
    assign pop_c  = (sel_c == PC_RET);
    assign push_c = ((sel_c == PC_RET) || (sel_c == PC_JUMP)) && call && jump;

    return_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (link_addr),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

    assign ret_target_c = stk_empty ? jump_target : stk_top;
    assign ras_empty    = stk_empty;
    assign ras_full     = stk_full;
`else
    logic unused_c;

    assign ret_target_c = jump_target;
    assign ras_empty    = 1'b1;
    assign ras_full     = 1'b0;
    assign unused_c     = ^{call, link_addr, 32'(RAS_DEPTH)};
`endif

endmodule : pc_sequencer
